// File: rtl/controle_contagem.sv
// rtl/controle_contagem.sv - debounced direction/clear buttons and prescaled tick for a downstream counter
// Buttons are synchronized, debounced, and edge-detected; the clear event also restarts the prescaler.
module controle_contagem #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PRESCALE        = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic botao_direcao,
  input  logic botao_zera,
  input  logic habilita,
  output logic Entrada_de_Selecao,
  output logic reset_contador,
  output logic tick
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(PRESCALE);

  // Bit 0 carries botao_direcao, bit 1 carries botao_zera.
  logic [1:0]         s1_q, s1_d;
  logic [1:0]         s2_q, s2_d;
  logic [1:0]         lvl_q, lvl_d;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0]         rise;
  logic [PW-1:0]      pre_q, pre_d;
  logic               wrap;
  logic               sel_q, sel_d;
  logic               rc_q, rc_d;
  logic               tick_q, tick_d;

  always_comb begin
    s1_d  = {botao_zera, botao_direcao};
    s2_d  = s1_q;
    lvl_d = lvl_q;
    cnt_d = '0;
    rise  = '0;
    for (int i = 0; i < 2; i++) begin
      if (s2_q[i] != lvl_q[i]) begin
        // The edge completing the run accepts the new level instead of counting further.
        if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          lvl_d[i] = s2_q[i];
          rise[i]  = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end

    sel_d  = sel_q ^ rise[0];
    rc_d   = rise[1];
    wrap   = (pre_q == PW'(PRESCALE - 1));
    pre_d  = pre_q;
    tick_d = 1'b0;
    if (rise[1]) begin
      pre_d = '0;
    end else if (habilita) begin
      tick_d = wrap;
      pre_d  = wrap ? '0 : pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      lvl_q  <= '0;
      cnt_q  <= '0;
      pre_q  <= '0;
      sel_q  <= 1'b1;
      rc_q   <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      lvl_q  <= lvl_d;
      cnt_q  <= cnt_d;
      pre_q  <= pre_d;
      sel_q  <= sel_d;
      rc_q   <= rc_d;
      tick_q <= tick_d;
    end
  end

  assign Entrada_de_Selecao = sel_q;
  assign reset_contador     = rc_q;
  assign tick               = tick_q;

endmodule
